plic_gateway_arb: RTL and testbench
===================================

PLIC_GATEWAY_ARB -- requirements
Module: plic_gateway_arb

Interface
- REQ-001: Parameter IRQ_NUM, default 32; number of source slots. Slot 0 is reserved and never pends, so sources are 1..IRQ_NUM-1.
- REQ-002: Parameter PRIO_WIDTH, default 3; width of each priority field and of the threshold.
- REQ-003: Port clk_i, input, 1 bit; the single clock, rising-edge.
- REQ-004: Port rst_i, input, 1 bit; reset, asynchronous, active-high.
- REQ-005: Port irq_i, input, IRQ_NUM bits; raw device interrupt lines.
- REQ-006: Port trig_i, input, IRQ_NUM bits; per-source trigger mode, 1 = rising-edge, 0 = level-high.
- REQ-007: Port ie_i, input, IRQ_NUM bits; per-source enable.
- REQ-008: Port prio_i, input, IRQ_NUM*PRIO_WIDTH bits; packed priorities, source i at [i*PRIO_WIDTH +: PRIO_WIDTH].
- REQ-009: Port thold_i, input, PRIO_WIDTH bits; target threshold.
- REQ-010: Port claim_i, input, 1 bit; single-cycle claim strobe.
- REQ-011: Port comp_i, input, 1 bit; single-cycle complete strobe.
- REQ-012: Port comp_id_i, input, log2(IRQ_NUM) bits; ID being completed.
- REQ-013: Port max_id_o, output, log2(IRQ_NUM) bits; registered winning ID, 0 = none.
- REQ-014: Port ext_irq_o, output, 1 bit; target interrupt request.
- REQ-015: Port ip_o, output, IRQ_NUM bits; pending bits, 1 when a source is in PEND.

Function
- REQ-016: Each source has a 3-state gateway FSM with states IDLE, PEND and INSV, plus a 1-bit edge_latch.
- REQ-017: IDLE->PEND when the request condition holds: level mode, irq_i[i]=1; edge mode, irq_i[i]=1 and the registered previous irq_i[i]=0.
- REQ-018: PEND->INSV on claim_i while max_id_q==i.
- REQ-019: INSV->IDLE on comp_i with comp_id_i==i; if edge_latch=1, go INSV->PEND instead and clear edge_latch.
- REQ-020: An edge-mode rising edge in PEND or INSV sets edge_latch; a second edge while edge_latch=1 is dropped; level requests in PEND or INSV are ignored.
- REQ-021: A source is eligible when it is in PEND, ie_i[i]=1 and prio_i[i]!=0.
- REQ-022: Winner is the highest priority among eligible sources, ties to the lowest ID; combinational, registered into max_id_q/max_prio_q, so latency is 1 cycle from input change to max_id_o.
- REQ-023: In the cycle after a claim, max_id_q and max_prio_q are forced to 0, so back-to-back claims return 0 on the second claim.
- REQ-024: ext_irq_o = (max_prio_q > thold_i), an unsigned compare, registered through max_prio_q; thold_i=0 with max_prio_q=0 gives 0.
- REQ-025: claim_i with max_id_q=0 changes no state.
- REQ-026: comp_i for an ID not in INSV, or for ID 0, is ignored.
- REQ-027: claim_i and comp_i in the same cycle are both applied independently.
- REQ-028: Request and claim in the same cycle for one edge source: the source goes to INSV and the edge sets edge_latch.
- REQ-029: Clearing ie_i[i] while a source is in PEND keeps it in PEND but removes it from arbitration.

Reset
- REQ-030: When rst_i is asserted, asynchronously: all FSMs IDLE, edge_latch=0, previous-irq registers 0, max_id_q=0, max_prio_q=0, hence ip_o=0 and ext_irq_o=0.
- REQ-031: Reset during INSV discards the claim; no completion is expected afterwards.

Configuration
- REQ-032: Macro PLIC_IRQ_SYNC_EN.
- REQ-033: With PLIC_IRQ_SYNC_EN defined, irq_i passes through a 2-flop synchronizer (reset 0) before the gateways, adding 2 cycles of request latency.
- REQ-034: Without PLIC_IRQ_SYNC_EN, irq_i feeds the gateways directly.

Structure
- REQ-035: The gateway state enum and the IRQ_NUM and PRIO_WIDTH defaults belong in the shared package plic_pkg.
- REQ-036: Per-source FSM plus edge logic is the sub-module plic_gateway, instantiated IRQ_NUM-1 times; the arbiter tree stays in the top.

Verification (no sync macro)
- REQ-037: Level src3, prio 2, ie=1, thold 0 -> ip_o[3]=1 next cycle, max_id_o=3 and ext_irq_o=1 one cycle later.
- REQ-038: src5 prio 4 and src2 prio 4 pending -> max_id_o=2; claim -> src2 INSV, max_id_o=0 next cycle, then 5.
- REQ-039: thold=4, only src7 prio 4 -> ext_irq_o=0; thold=3 -> ext_irq_o=1 after 1 cycle.
- REQ-040: Edge src9: claim, then 2 pulses during INSV, then comp 9 -> src9 PEND once more; after its next claim and comp -> IDLE.
- REQ-041: comp_id_i=6 while src6 is IDLE -> no change; back-to-back claim -> second claim sees max_id_o=0 and changes nothing.
- REQ-042: rst_i asserted mid-INSV -> all outputs 0 immediately; the level request re-pends 1 cycle after reset release.

Source files
------------

// File: rtl/plic_pkg.sv
// ============================================================================
// Module : plic_pkg
// Brief  : Shared types and default sizes for the PLIC gateway/arbiter block.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package plic_pkg;

    localparam int IRQ_NUM_DEF    = 32;
    localparam int PRIO_WIDTH_DEF = 3;

    typedef enum logic [1:0] {
        GW_IDLE = 2'd0,
        GW_PEND = 2'd1,
        GW_INSV = 2'd2
    } gw_state_e;

endpackage

`default_nettype wire

// File: rtl/plic_gateway.sv
// ============================================================================
// Module : plic_gateway
// Brief  : Per-source interrupt gateway: IDLE/PEND/INSV FSM with edge latch.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module plic_gateway
    import plic_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_irq,
    input  logic i_trig,
    input  logic i_claim,
    input  logic i_comp,
    output logic o_pend
);

    gw_state_e r_state;
    gw_state_e w_state_nxt;
    logic      r_prev;
    logic      r_latch;
    logic      w_latch_nxt;
    logic      w_edge;
    logic      w_req;

    assign w_edge = i_trig & i_irq & ~r_prev;
    assign w_req  = i_trig ? w_edge : i_irq;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= GW_IDLE;
            r_prev  <= 1'b0;
            r_latch <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_prev  <= i_irq;
            r_latch <= w_latch_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch_nxt = r_latch;
        case (r_state)
            GW_IDLE: begin
                if (w_req) begin
                    w_state_nxt = GW_PEND;
                end
            end
            GW_PEND: begin
                if (w_edge) begin
                    w_latch_nxt = 1'b1;
                end
                if (i_claim) begin
                    w_state_nxt = GW_INSV;
                end
            end
            GW_INSV: begin
                if (w_edge) begin
                    w_latch_nxt = 1'b1;
                end
                // An edge arriving with the completion is treated as latched so it is not lost.
                if (i_comp) begin
                    w_latch_nxt = 1'b0;
                    w_state_nxt = (r_latch || w_edge) ? GW_PEND : GW_IDLE;
                end
            end
            default: begin
                w_state_nxt = GW_IDLE;
                w_latch_nxt = 1'b0;
            end
        endcase
    end

    assign o_pend = (r_state == GW_PEND);

endmodule

`default_nettype wire

// File: rtl/plic_gateway_arb.sv
// ============================================================================
// Module : plic_gateway_arb
// Brief  : PLIC gateways plus priority arbiter for one target.
//          Optional input synchronizer enabled by macro PLIC_IRQ_SYNC_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module plic_gateway_arb
    import plic_pkg::*;
#(
    parameter int IRQ_NUM    = IRQ_NUM_DEF,
    parameter int PRIO_WIDTH = PRIO_WIDTH_DEF,
    localparam int ID_W      = $clog2(IRQ_NUM)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [IRQ_NUM-1:0]            irq_i,
    input  logic [IRQ_NUM-1:0]            trig_i,
    input  logic [IRQ_NUM-1:0]            ie_i,
    input  logic [IRQ_NUM*PRIO_WIDTH-1:0] prio_i,
    input  logic [PRIO_WIDTH-1:0]         thold_i,
    input  logic                          claim_i,
    input  logic                          comp_i,
    input  logic [ID_W-1:0]               comp_id_i,
    output logic [ID_W-1:0]               max_id_o,
    output logic                          ext_irq_o,
    output logic [IRQ_NUM-1:0]            ip_o
);

    logic [IRQ_NUM-1:0]    w_irq;
    logic [IRQ_NUM-1:0]    w_pend;
    logic [ID_W-1:0]       w_best_id;
    logic [PRIO_WIDTH-1:0] w_best_prio;
    logic [ID_W-1:0]       r_max_id;
    logic [PRIO_WIDTH-1:0] r_max_prio;
    logic                  w_unused_ok;

`ifdef PLIC_IRQ_SYNC_EN
    logic [IRQ_NUM-1:0] r_sync1;
    logic [IRQ_NUM-1:0] r_sync2;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_irq = r_sync2;
`else
    assign w_irq = irq_i;
`endif

    // Slot 0 is reserved: it has no gateway and never pends.
    assign w_pend[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < IRQ_NUM; gi++) begin : g_gw
            plic_gateway u_gw (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .i_irq   (w_irq[gi]),
                .i_trig  (trig_i[gi]),
                .i_claim (claim_i && (r_max_id == ID_W'(gi))),
                .i_comp  (comp_i && (comp_id_i == ID_W'(gi))),
                .o_pend  (w_pend[gi])
            );
        end
    endgenerate

    // Strict greater-than keeps the lowest ID on ties and rejects priority 0.
    always_comb begin
        w_best_id   = '0;
        w_best_prio = '0;
        for (int i = 1; i < IRQ_NUM; i++) begin
            if (w_pend[i] && ie_i[i] &&
                (prio_i[i*PRIO_WIDTH +: PRIO_WIDTH] > w_best_prio)) begin
                w_best_id   = ID_W'(i);
                w_best_prio = prio_i[i*PRIO_WIDTH +: PRIO_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_max_id   <= '0;
            r_max_prio <= '0;
        end else if (claim_i) begin
            r_max_id   <= '0;
            r_max_prio <= '0;
        end else begin
            r_max_id   <= w_best_id;
            r_max_prio <= w_best_prio;
        end
    end

    assign max_id_o  = r_max_id;
    assign ext_irq_o = (r_max_prio > thold_i);
    assign ip_o      = w_pend;

    assign w_unused_ok = ^{ie_i[0], trig_i[0], prio_i[PRIO_WIDTH-1:0], w_irq[0], w_pend[0]};

endmodule

`default_nettype wire

// File: tb/tb_plic_gateway_arb.sv
// ============================================================================
// Module : tb_plic_gateway_arb
// Brief  : Directed self-checking bench for plic_gateway_arb (default build).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_plic_gateway_arb;

    localparam int N  = 32;
    localparam int PW = 3;

    logic          clk;
    logic          rst;
    logic [N-1:0]  irq;
    logic [N-1:0]  trig;
    logic [N-1:0]  ie;
    logic [N*PW-1:0] prio;
    logic [PW-1:0] thold;
    logic          claim;
    logic          comp;
    logic [4:0]    comp_id;
    logic [4:0]    max_id;
    logic          ext_irq;
    logic [N-1:0]  ip;

    int n_total = 0;
    int n_bad   = 0;

    plic_gateway_arb u_dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .irq_i     (irq),
        .trig_i    (trig),
        .ie_i      (ie),
        .prio_i    (prio),
        .thold_i   (thold),
        .claim_i   (claim),
        .comp_i    (comp),
        .comp_id_i (comp_id),
        .max_id_o  (max_id),
        .ext_irq_o (ext_irq),
        .ip_o      (ip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_prio(input int id, input logic [PW-1:0] p);
        prio[id*PW +: PW] = p;
    endtask

    task automatic do_claim();
        claim = 1'b1;
        step();
        claim = 1'b0;
    endtask

    task automatic do_comp(input logic [4:0] id);
        comp    = 1'b1;
        comp_id = id;
        step();
        comp    = 1'b0;
        comp_id = '0;
    endtask

    initial begin
        rst = 1'b1; irq = '0; trig = '0; ie = '0; prio = '0;
        thold = '0; claim = 1'b0; comp = 1'b0; comp_id = '0;
        #1;
        check_eq("rst_ip", ip, 32'h0);
        check_eq("rst_max_id", {27'b0, max_id}, 32'd0);
        check_eq("rst_ext", {31'b0, ext_irq}, 32'd0);
        step(); step();
        rst = 1'b0;
        step();

        // Level source 3, priority 2, threshold 0
        irq[3] = 1'b1; ie[3] = 1'b1; set_prio(3, 3'd2);
        step();
        check_eq("lvl3_ip", {31'b0, ip[3]}, 32'd1);
        check_eq("lvl3_id_lat", {27'b0, max_id}, 32'd0);
        step();
        check_eq("lvl3_id", {27'b0, max_id}, 32'd3);
        check_eq("lvl3_ext", {31'b0, ext_irq}, 32'd1);
        do_claim();
        check_eq("lvl3_insv_ip", {31'b0, ip[3]}, 32'd0);
        check_eq("lvl3_claim_id", {27'b0, max_id}, 32'd0);
        irq[3] = 1'b0;
        do_comp(5'd3);
        step();
        check_eq("lvl3_idle_ip", ip, 32'h0);

        // Tie between sources 5 and 2 at priority 4
        irq[5] = 1'b1; irq[2] = 1'b1; ie[5] = 1'b1; ie[2] = 1'b1;
        set_prio(5, 3'd4); set_prio(2, 3'd4);
        step(); step();
        check_eq("tie_id", {27'b0, max_id}, 32'd2);
        do_claim();
        irq[2] = 1'b0;
        check_eq("tie_claim_id", {27'b0, max_id}, 32'd0);
        check_eq("tie_ip", ip, 32'h0000_0020);
        step();
        check_eq("tie_next_id", {27'b0, max_id}, 32'd5);
        do_claim();
        irq[5] = 1'b0;
        do_comp(5'd5);
        do_comp(5'd2);
        check_eq("tie_clean_ip", ip, 32'h0);
        step();

        // Threshold compare on source 7 at priority 4
        thold = 3'd4;
        irq[7] = 1'b1; ie[7] = 1'b1; set_prio(7, 3'd4);
        step(); step();
        check_eq("thr_id", {27'b0, max_id}, 32'd7);
        check_eq("thr_eq_ext", {31'b0, ext_irq}, 32'd0);
        thold = 3'd3;
        step();
        check_eq("thr_lt_ext", {31'b0, ext_irq}, 32'd1);
        do_claim();
        irq[7] = 1'b0;
        do_comp(5'd7);
        thold = 3'd0;
        step();

        // Edge source 9: two pulses while in service collapse to one re-pend
        trig[9] = 1'b1; ie[9] = 1'b1; set_prio(9, 3'd5);
        irq[9] = 1'b1; step(); irq[9] = 1'b0;
        check_eq("edge_ip", {31'b0, ip[9]}, 32'd1);
        step();
        check_eq("edge_id", {27'b0, max_id}, 32'd9);
        do_claim();
        for (int k = 0; k < 2; k++) begin
            irq[9] = 1'b1; step();
            irq[9] = 1'b0; step();
        end
        check_eq("edge_insv_ip", {31'b0, ip[9]}, 32'd0);
        do_comp(5'd9);
        check_eq("edge_repend_ip", {31'b0, ip[9]}, 32'd1);
        step();
        check_eq("edge_repend_id", {27'b0, max_id}, 32'd9);
        do_claim();
        do_comp(5'd9);
        check_eq("edge_idle_ip", {31'b0, ip[9]}, 32'd0);
        step();
        check_eq("edge_idle_id", {27'b0, max_id}, 32'd0);

        // Completion of an idle source is ignored
        do_comp(5'd6);
        check_eq("comp_idle_ip", ip, 32'h0);
        check_eq("comp_idle_id", {27'b0, max_id}, 32'd0);

        // Disabling a pending source keeps it pending but out of arbitration
        irq[4] = 1'b1; ie[4] = 1'b1; set_prio(4, 3'd3);
        step(); step();
        check_eq("ie_id", {27'b0, max_id}, 32'd4);
        ie[4] = 1'b0;
        step();
        check_eq("ie_off_ip", {31'b0, ip[4]}, 32'd1);
        check_eq("ie_off_id", {27'b0, max_id}, 32'd0);
        ie[4] = 1'b1;
        step();
        check_eq("ie_on_id", {27'b0, max_id}, 32'd4);

        // Back-to-back claims: the second sees ID 0 and changes nothing
        do_claim();
        check_eq("b2b_first_id", {27'b0, max_id}, 32'd0);
        do_claim();
        check_eq("b2b_second_id", {27'b0, max_id}, 32'd0);
        check_eq("b2b_ip", ip, 32'h0);

        // Asynchronous reset while source 4 is in service, level still high
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_ip", ip, 32'h0);
        check_eq("arst_id", {27'b0, max_id}, 32'd0);
        check_eq("arst_ext", {31'b0, ext_irq}, 32'd0);
        step();
        rst = 1'b0;
        check_eq("arst_hold_ip", ip, 32'h0);
        step();
        check_eq("arst_repend_ip", {31'b0, ip[4]}, 32'd1);
        step();
        check_eq("arst_repend_id", {27'b0, max_id}, 32'd4);
        check_eq("arst_repend_ext", {31'b0, ext_irq}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
